// File: rtl/up_down_count_monitor_if.sv
// rtl/up_down_count_monitor_if.sv - sample stream and status bundle between a count source and the monitor
//
// Signals:
//   in_en       sample strobe from the source
//   In          observed count value
//   Mode_det    detected direction (1=up, 0=down)
//   locked      direction tracking valid
//   dir_change  one-cycle pulse on a reversal while locked
//   step_err    one-cycle pulse on an illegal step while locked
//   err_count   saturating count of step_err events
//   last_val    most recent sampled In
// Modports: master drives the sample stream and reads status; slave is the monitor.
interface up_down_count_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_en;
    logic [WIDTH-1:0] In;
    logic             Mode_det;
    logic             locked;
    logic             dir_change;
    logic             step_err;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_val;

    modport master (
        output in_en, In,
        input  Mode_det, locked, dir_change, step_err, err_count, last_val
    );

    modport slave (
        input  in_en, In,
        output Mode_det, locked, dir_change, step_err, err_count, last_val
    );
endinterface

// File: rtl/up_down_count_monitor.sv
// rtl/up_down_count_monitor.sv - infers up/down direction of a count stream and flags sequence errors
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    up_down_count_monitor_if.slave: in_en/In sample stream in,
//          Mode_det/locked/dir_change/step_err/err_count/last_val status out
// Parameters: WIDTH (count width, mod 2^WIDTH arithmetic), LOCK_CNT (same-direction
// steps needed to lock, >=1), ERR_W (error counter width). WIDTH and ERR_W must
// match the connected interface.
module up_down_count_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    up_down_count_monitor_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        EMPTY,
        ACQ,
        LOCK
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_SKIP
    } step_t;

    state_t             state_q, state_n;
    logic [RUN_W-1:0]   run_q, run_n;
    logic               cand_q, cand_n;
    logic               mode_q, mode_n;
    logic               locked_q;
    logic               dir_change_q, dir_change_n;
    logic               step_err_q, step_err_n;
    logic [ERR_W-1:0]   err_q, err_n;
    logic [WIDTH-1:0]   last_val_q, last_val_n;

    logic [WIDTH-1:0]   delta;
    step_t              step;
    logic               is_move;
    logic               step_dir;

    // Modular subtraction makes wrap-around (max->0 up, 0->max down) a legal step.
    assign delta = bus.In - last_val_q;

    always_comb begin
        step = STEP_SKIP;
        if (delta == WIDTH'(0))
            step = STEP_HOLD;
        else if (delta == WIDTH'(1))
            step = STEP_UP;
        else if (delta == {WIDTH{1'b1}})
            step = STEP_DOWN;
    end

    assign is_move  = (step == STEP_UP) || (step == STEP_DOWN);
    assign step_dir = (step == STEP_UP);

    always_comb begin
        state_n      = state_q;
        run_n        = run_q;
        cand_n       = cand_q;
        mode_n       = mode_q;
        err_n        = err_q;
        last_val_n   = last_val_q;
        dir_change_n = 1'b0;
        step_err_n   = 1'b0;

        if (bus.in_en) begin
            last_val_n = bus.In;
            case (state_q)
                EMPTY: begin
                    state_n = ACQ;
                    run_n   = '0;
                end
                ACQ: begin
                    if (is_move) begin
                        // A fresh run (run=0) adopts whatever direction arrives first.
                        if ((run_q == '0) || (step_dir == cand_q))
                            run_n = run_q + RUN_W'(1);
                        else
                            run_n = RUN_W'(1);
                        cand_n = step_dir;
                        if (run_n >= RUN_W'(LOCK_CNT)) begin
                            state_n = LOCK;
                            mode_n  = step_dir;
                        end
                    end else if (step == STEP_SKIP) begin
                        run_n = '0;
                    end
                end
                LOCK: begin
                    if (is_move && (step_dir != mode_q)) begin
                        mode_n       = step_dir;
                        dir_change_n = 1'b1;
                    end else if (step == STEP_SKIP) begin
                        step_err_n = 1'b1;
                        if (err_q != {ERR_W{1'b1}})
                            err_n = err_q + ERR_W'(1);
                        state_n = ACQ;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    run_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            run_q        <= '0;
            cand_q       <= 1'b1;
            mode_q       <= 1'b1;
            locked_q     <= 1'b0;
            dir_change_q <= 1'b0;
            step_err_q   <= 1'b0;
            err_q        <= '0;
            last_val_q   <= '0;
        end else begin
            state_q      <= state_n;
            run_q        <= run_n;
            cand_q       <= cand_n;
            mode_q       <= mode_n;
            locked_q     <= (state_n == LOCK);
            dir_change_q <= dir_change_n;
            step_err_q   <= step_err_n;
            err_q        <= err_n;
            last_val_q   <= last_val_n;
        end
    end

    assign bus.Mode_det   = mode_q;
    assign bus.locked     = locked_q;
    assign bus.dir_change = dir_change_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_count  = err_q;
    assign bus.last_val   = last_val_q;
endmodule

// File: tb/tb_up_down_count_monitor.sv
// tb/tb_up_down_count_monitor.sv - bench for up_down_count_monitor across three parameter sets
module tb_up_down_count_monitor;
    localparam int MOD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    up_down_count_monitor_if #(.WIDTH(4), .ERR_W(8)) if0 ();
    up_down_count_monitor_if #(.WIDTH(4), .ERR_W(2)) if1 ();
    up_down_count_monitor_if #(.WIDTH(4), .ERR_W(8)) if2 ();

    up_down_count_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    up_down_count_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    up_down_count_monitor #(.WIDTH(4), .LOCK_CNT(1), .ERR_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        int phase;   // 0 = nothing seen yet, 1 = acquiring, 2 = locked
        int run;
        int cand;
        int mode;
        int locked;
        int dc;
        int se;
        int errs;
        int last;
    } model_t;

    model_t m0, m1, m2;

    function automatic model_t model_reset();
        model_t s;
        s.phase = 0; s.run = 0; s.cand = 1; s.mode = 1; s.locked = 0;
        s.dc = 0; s.se = 0; s.errs = 0; s.last = 0;
        return s;
    endfunction

    // Direction inference from the observed value sequence: +1 is up, -1 is down,
    // 0 is a hold, any other difference is a skipped or corrupted value.
    function automatic model_t model_step(model_t s, bit en, int v, int lock_cnt, int err_max);
        int d;
        int dir;
        bit moved, skipped;
        s.dc = 0;
        s.se = 0;
        if (!en) return s;
        d = ((v - s.last) % MOD + MOD) % MOD;
        moved   = (d == 1) || (d == MOD - 1);
        skipped = (d != 0) && !moved;
        dir     = (d == 1) ? 1 : 0;
        if (s.phase == 0) begin
            s.phase = 1;
            s.run = 0;
        end else if (s.phase == 1) begin
            if (moved) begin
                s.run  = (s.run == 0 || dir == s.cand) ? s.run + 1 : 1;
                s.cand = dir;
                if (s.run >= lock_cnt) begin
                    s.phase = 2;
                    s.locked = 1;
                    s.mode = dir;
                end
            end else if (skipped) begin
                s.run = 0;
            end
        end else begin
            if (moved && dir != s.mode) begin
                s.mode = dir;
                s.dc = 1;
            end else if (skipped) begin
                s.se = 1;
                s.errs = (s.errs < err_max) ? s.errs + 1 : err_max;
                s.phase = 1;
                s.run = 0;
                s.locked = 0;
            end
        end
        s.last = v;
        return s;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic cmp_one(input string tag, input model_t m, input int mode, input int locked,
                           input int dc, input int se, input int errs, input int lastv);
        check({tag, ".Mode_det"},   mode,   m.mode);
        check({tag, ".locked"},     locked, m.locked);
        check({tag, ".dir_change"}, dc,     m.dc);
        check({tag, ".step_err"},   se,     m.se);
        check({tag, ".err_count"},  errs,   m.errs);
        check({tag, ".last_val"},   lastv,  m.last);
    endtask

    task automatic compare_all(input string tag);
        cmp_one({tag, "/d0"}, m0, int'(if0.Mode_det), int'(if0.locked), int'(if0.dir_change),
                int'(if0.step_err), int'(if0.err_count), int'(if0.last_val));
        cmp_one({tag, "/d1"}, m1, int'(if1.Mode_det), int'(if1.locked), int'(if1.dir_change),
                int'(if1.step_err), int'(if1.err_count), int'(if1.last_val));
        cmp_one({tag, "/d2"}, m2, int'(if2.Mode_det), int'(if2.locked), int'(if2.dir_change),
                int'(if2.step_err), int'(if2.err_count), int'(if2.last_val));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input bit en, input int v);
        if0.in_en = en; if1.in_en = en; if2.in_en = en;
        if0.In = 4'(v); if1.In = 4'(v); if2.In = 4'(v);
        @(posedge clk);
        m0 = model_step(m0, en, v, 2, 255);
        m1 = model_step(m1, en, v, 2, 3);
        m2 = model_step(m2, en, v, 1, 255);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m0 = model_reset(); m1 = model_reset(); m2 = model_reset();
        check({tag, ".locked"},    int'(if0.locked), 0);
        check({tag, ".Mode_det"},  int'(if0.Mode_det), 1);
        check({tag, ".err_count"}, int'(if0.err_count), 0);
        check({tag, ".last_val"},  int'(if0.last_val), 0);
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur, dir, r;
        if0.in_en = 1'b0; if1.in_en = 1'b0; if2.in_en = 1'b0;
        if0.In = '0; if1.In = '0; if2.In = '0;
        m0 = model_reset(); m1 = model_reset(); m2 = model_reset();
        @(negedge clk);
        #1;
        compare_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Lock across the 15->0 wrap
        step("wrap14", 1, 14);
        step("wrap15", 1, 15);
        step("wrap0", 1, 0);
        check("wrap_locked", int'(if0.locked), 1);
        check("wrap_mode", int'(if0.Mode_det), 1);
        step("wrap1", 1, 1);
        check("wrap_no_err", int'(if0.err_count), 0);

        // Mid-stream async reset, then a first sample
        do_reset("rst_mid");
        step("after_rst9", 1, 9);
        check("after_rst_locked", int'(if0.locked), 0);
        check("after_rst_err", int'(if0.step_err), 0);

        // Direction change while locked
        do_reset("rst_dc");
        step("dc5", 1, 5);
        step("dc6", 1, 6);
        step("dc7", 1, 7);
        step("dc6b", 1, 6);
        check("dc_pulse", int'(if0.dir_change), 1);
        check("dc_mode", int'(if0.Mode_det), 0);
        step("dc5b", 1, 5);
        check("dc_once", int'(if0.dir_change), 0);
        check("dc_locked", int'(if0.locked), 1);

        // Skip while locked, then relock
        do_reset("rst_skip");
        step("sk3", 1, 3);
        step("sk4", 1, 4);
        step("sk5", 1, 5);
        step("sk7", 1, 7);
        check("skip_err", int'(if0.step_err), 1);
        check("skip_cnt", int'(if0.err_count), 1);
        check("skip_unlock", int'(if0.locked), 0);
        step("sk8", 1, 8);
        step("sk9", 1, 9);
        check("skip_relock", int'(if0.locked), 1);

        // Holds with strobe gaps
        do_reset("rst_hold");
        step("h3", 1, 3);
        step("h4", 1, 4);
        step("h5", 1, 5);
        step("h5a", 1, 5);
        step("h5b", 0, 5);
        step("h5c", 1, 5);
        step("h9g", 0, 9);
        check("hold_locked", int'(if0.locked), 1);
        check("hold_err", int'(if0.err_count), 0);

        // Repeated relock/skip: ERR_W=2 counter saturates at 3
        do_reset("rst_sat");
        begin
            int seq [19] = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 15, 0, 1, 4, 5, 6, 9, 10, 11, 14};
            foreach (seq[i]) step("sat", 1, seq[i]);
        end
        check("sat_w2", int'(if1.err_count), 3);
        check("sat_w8", int'(if0.err_count), 6);

        // LOCK_CNT=1 locks on the first step
        do_reset("rst_lc1");
        step("lc2", 1, 2);
        step("lc1", 1, 1);
        check("lc1_locked", int'(if2.locked), 1);
        check("lc1_mode", int'(if2.Mode_det), 0);

        // Randomised count stream with reversals, holds, skips and gaps
        do_reset("rst_rand");
        cur = $urandom_range(0, 15);
        dir = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                step("rnd_gap", 0, $urandom_range(0, 15));
            end else begin
                if (r < 70)       cur = (cur + (dir ? 1 : MOD - 1)) % MOD;
                else if (r < 80) begin
                    dir = 1 - dir;
                    cur = (cur + (dir ? 1 : MOD - 1)) % MOD;
                end
                else if (r < 88)  cur = cur;
                else              cur = (cur + $urandom_range(2, 14)) % MOD;
                step("rnd", 1, cur);
            end
            if (i == 200) do_reset("rst_rand_mid");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
